// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
interface div_if #(
  parameter int unsigned WIDTH = 32
);
  logic               div_start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               annul;
  logic               stallreq_for_ex;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output div_start, signed_div, opdata1, opdata2, annul,
    input  stallreq_for_ex, ready, result
  );

  modport slave (
    input  div_start, signed_div, opdata1, opdata2, annul,
    output stallreq_for_ex, ready, result
  );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 shift-subtract divider sequencer for the EX stage: one quotient bit
// per cycle, stall request toward the pipeline, one-cycle {rem, quo} result.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned WORK_W = 2 * WIDTH + 1;
  localparam int unsigned RES_W  = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [WIDTH-1:0]    divisor_q, divisor_d;
  logic                signed_q, signed_d;
  logic                sign1_q, sign1_d;
  logic                sign2_q, sign2_d;
  logic                ready_q, ready_d;
  logic [RES_W-1:0]    result_q, result_d;

  logic [WORK_W-1:0]   work_sh;
  logic [WIDTH+1:0]    trial;
  logic [WIDTH-1:0]    quo_abs, rem_abs, quo_fix, rem_fix;
  logic [WIDTH-1:0]    abs1, abs2;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  // Operand magnitudes; raw values in unsigned mode
  assign abs1 = (bus.signed_div && bus.opdata1[WIDTH-1]) ? WIDTH'(-bus.opdata1) : bus.opdata1;
  assign abs2 = (bus.signed_div && bus.opdata2[WIDTH-1]) ? WIDTH'(-bus.opdata2) : bus.opdata2;

  // Shift, then trial-subtract divisor from the upper WIDTH+1 bits; MSB of trial is the borrow
  assign work_sh = WORK_W'({work_q, 1'b0});
  assign trial   = {1'b0, work_sh[WORK_W-1:WIDTH]} - {2'b00, divisor_q};

  assign quo_abs = work_q[WIDTH-1:0];
  assign rem_abs = work_q[RES_W-1:WIDTH];
  assign quo_fix = (signed_q && (sign1_q != sign2_q)) ? WIDTH'(-quo_abs) : quo_abs;
  assign rem_fix = (signed_q && sign1_q) ? WIDTH'(-rem_abs) : rem_abs;

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    ready_d   = 1'b0;
    result_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.div_start && !bus.annul) begin
          signed_d  = bus.signed_div;
          sign1_d   = bus.opdata1[WIDTH-1];
          sign2_d   = bus.opdata2[WIDTH-1];
          divisor_d = abs2;
          work_d    = {(WIDTH + 1)'(0), abs1};
          cnt_d     = '0;
          state_d   = (bus.opdata2 == '0) ? DIVZERO : ON;
        end
      end
      DIVZERO: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          state_d = END;
          ready_d = 1'b1;
        end
      end
      ON: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else if (cnt_q < CNT_W'(WIDTH)) begin
          work_d = work_sh;
          if (!trial[WIDTH+1]) begin
            work_d[WORK_W-1:WIDTH] = trial[WIDTH:0];
            work_d[0]              = 1'b1;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall drops in END so the owning instruction leaves EX while ready is shown
  assign bus.stallreq_for_ex = !bus.annul &&
                               (((state_q == IDLE) && bus.div_start) ||
                                (state_q == ON) || (state_q == DIVZERO));
  assign bus.ready  = ready_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table of divides plus annul/reset/back-to-back sequences.
module tb_div_ctrl;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) bus ();

  div_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic           sdiv;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    int             end_cyc;
  } vec_t;

  vec_t vecs[11];
  vec_t v_b2b;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a divide in the next cycle (cycle 0) and checks every cycle through END.
  task automatic run_div(input vec_t v, input string tag, input bit hold);
    step();
    bus.div_start  = 1'b1;
    bus.signed_div = v.sdiv;
    bus.opdata1    = v.a;
    bus.opdata2    = v.b;
    #1;
    for (int c = 0; c <= v.end_cyc; c++) begin
      if (c > 0) step();
      if (c == 1) begin
        bus.opdata1    = ~v.a;
        bus.opdata2    = '0;
        bus.signed_div = ~v.sdiv;
      end
      chk_bit($sformatf("%s_stall_c%0d", tag, c), bus.stallreq_for_ex, c < v.end_cyc);
      chk_bit($sformatf("%s_ready_c%0d", tag, c), bus.ready, c == v.end_cyc);
      if (c == v.end_cyc) chk_res($sformatf("%s_result", tag), bus.result, v.exp);
    end
    if (!hold) begin
      bus.div_start = 1'b0;
      step();
      chk_bit($sformatf("%s_idle_ready", tag), bus.ready, 1'b0);
      chk_res($sformatf("%s_idle_result", tag), bus.result, '0);
      chk_bit($sformatf("%s_idle_stall", tag), bus.stallreq_for_ex, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.div_start  = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,        {32'h00000002, 32'h0000000E}, 34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 34};
    vecs[2]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 34};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        {32'h00000000, 32'hFFFFFFFF}, 34};
    vecs[4]  = '{1'b0, 32'd1234,      32'd0,        64'h0,                        2};
    vecs[5]  = '{1'b1, 32'd100,       32'hFFFFFFF9, {32'h00000002, 32'hFFFFFFF2}, 34};
    vecs[6]  = '{1'b0, 32'hFFFFFFF9,  32'd2,        {32'h00000001, 32'h7FFFFFFC}, 34};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 34};
    vecs[8]  = '{1'b0, 32'd5,         32'd9,        {32'h00000005, 32'h00000000}, 34};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF,  32'd0,        64'h0,                        2};
    vecs[10] = '{1'b0, 32'h80000000,  32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 34};
    v_b2b    = '{1'b0, 32'd9,         32'd3,        {32'h00000000, 32'h00000003}, 34};

    // Reset state
    repeat (3) step();
    chk_bit("rst_ready", bus.ready, 1'b0);
    chk_res("rst_result", bus.result, '0);
    rst = 1'b0;
    step();
    chk_bit("post_rst_ready", bus.ready, 1'b0);
    chk_bit("post_rst_stall", bus.stallreq_for_ex, 1'b0);

    for (int i = 0; i < 11; i++) run_div(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // Back-to-back: new start in the IDLE cycle right after END
    run_div(vecs[0], "b2b_first", 1'b1);
    run_div(v_b2b, "b2b_second", 1'b0);

    // annul at cycle 10 of a divide
    step();
    bus.div_start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    for (int c = 1; c < 10; c++) step();
    step();
    bus.annul = 1'b1;
    #1;
    chk_bit("annul_on_stall_c10", bus.stallreq_for_ex, 1'b0);
    step();
    bus.annul = 1'b0; bus.div_start = 1'b0;
    #1;
    chk_bit("annul_on_stall_c11", bus.stallreq_for_ex, 1'b0);
    chk_bit("annul_on_ready_c11", bus.ready, 1'b0);
    for (int c = 12; c < 50; c++) begin
      step();
      chk_bit($sformatf("annul_on_ready_c%0d", c), bus.ready, 1'b0);
    end

    // annul during DIVZERO
    step();
    bus.div_start = 1'b1; bus.opdata1 = 32'd1234; bus.opdata2 = 32'd0;
    step();
    bus.annul = 1'b1; bus.div_start = 1'b0;
    #1;
    chk_bit("annul_dz_stall", bus.stallreq_for_ex, 1'b0);
    step();
    bus.annul = 1'b0;
    chk_bit("annul_dz_ready_c2", bus.ready, 1'b0);
    step();
    chk_bit("annul_dz_ready_c3", bus.ready, 1'b0);

    // annul in END leaves that cycle's ready visible
    run_div(vecs[3], "annul_end", 1'b1);
    bus.annul = 1'b1; bus.div_start = 1'b0;
    #1;
    chk_bit("annul_end_ready", bus.ready, 1'b1);
    chk_bit("annul_end_stall", bus.stallreq_for_ex, 1'b0);
    step();
    bus.annul = 1'b0;
    chk_bit("annul_end_next_ready", bus.ready, 1'b0);
    chk_res("annul_end_next_result", bus.result, '0);

    // rst at cycle 20 of a divide
    step();
    bus.div_start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    for (int c = 1; c < 20; c++) step();
    step();
    rst = 1'b1; bus.div_start = 1'b0;
    step();
    chk_bit("midrst_ready", bus.ready, 1'b0);
    chk_res("midrst_result", bus.result, '0);
    chk_bit("midrst_stall", bus.stallreq_for_ex, 1'b0);
    rst = 1'b0;
    for (int c = 22; c < 50; c++) begin
      step();
      chk_bit($sformatf("midrst_ready_c%0d", c), bus.ready, 1'b0);
    end
    run_div(vecs[7], "after_rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
